// File: rtl/bus_arbiter_card_pkg.sv
// Shared types and defaults for the backplane bus arbiter: FSM state encoding and a one-hot helper.
package bus_arbiter_card_pkg;

  localparam int ARB_NREQ_DEFAULT     = 4;
  localparam int ARB_MAX_HOLD_DEFAULT = 16;
  localparam int ARB_MAX_NREQ         = 8;

  typedef enum logic [1:0] {
    ARB_ST_IDLE  = 2'd0,
    ARB_ST_GRANT = 2'd1,
    ARB_ST_TURN  = 2'd2
  } arb_state_t;

  function automatic logic [ARB_MAX_NREQ-1:0] arb_onehot(input logic [2:0] idx);
    logic [ARB_MAX_NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/bus_arbiter_card_if.sv
// Backplane request/grant bundle; master modport is a bus-master card, slave modport is the arbiter.
interface bus_arbiter_card_if
  import bus_arbiter_card_pkg::*;
#(
  parameter int NREQ = ARB_NREQ_DEFAULT
);
  localparam int OWNER_W = $clog2(NREQ);

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    lock;
  logic [NREQ-1:0]    gnt;
  logic [OWNER_W-1:0] owner;
  logic               owner_vld;
  logic               preempt;

  modport master (
    output req,
    output lock,
    input  gnt,
    input  owner,
    input  owner_vld,
    input  preempt
  );

  modport slave (
    input  req,
    input  lock,
    output gnt,
    output owner,
    output owner_vld,
    output preempt
  );

endinterface

// File: rtl/bus_arbiter_card_rr_pick.sv
// Combinational round-robin picker: first set req bit searching last+1, last+2, ... modulo NREQ.
module bus_arbiter_card_rr_pick #(
  parameter  int NREQ    = 4,
  localparam int OWNER_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]    req,
  input  logic [OWNER_W-1:0] last,
  output logic [OWNER_W-1:0] winner,
  output logic               any
);

  always_comb begin
    logic [OWNER_W-1:0] idx;
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = OWNER_W'((int'(last) + i) % NREQ);
      if (!any && req[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_card.sv
// Round-robin backplane bus arbiter with held ownership and a one-cycle turnaround; grant 1 edge after IDLE request.
// Optional hold-limit preemption built when BUS_ARB_PREEMPT_EN is defined; otherwise grants last until release.
module bus_arbiter_card
  import bus_arbiter_card_pkg::*;
#(
  parameter int NREQ     = ARB_NREQ_DEFAULT,
  parameter int MAX_HOLD = ARB_MAX_HOLD_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  bus_arbiter_card_if.slave bus
);

  localparam int OWNER_W = $clog2(NREQ);

  if (NREQ < 2 || NREQ > ARB_MAX_NREQ) begin : g_bad_nreq
    $error("bus_arbiter_card: NREQ must be within 2..8");
  end
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("bus_arbiter_card: MAX_HOLD must be within 2..255");
  end

  arb_state_t         state;
  arb_state_t         state_nxt;
  logic [OWNER_W-1:0] last;
  logic [OWNER_W-1:0] last_nxt;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    gnt_nxt;
  logic [OWNER_W-1:0] owner;
  logic [OWNER_W-1:0] owner_nxt;
  logic               owner_vld;
  logic               owner_vld_nxt;
  logic               release_bus;

  logic [OWNER_W-1:0] pick_winner;
  logic               pick_any;

  bus_arbiter_card_rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req    (bus.req),
    .last   (last),
    .winner (pick_winner),
    .any    (pick_any)
  );

`ifdef BUS_ARB_PREEMPT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold_cnt;
  logic [7:0] hold_nxt;
  logic       preempt;
  logic       preempt_nxt;
  logic       others_req;

  // In GRANT, gnt is exactly the owner's bit, so masking it leaves the competing requesters.
  assign others_req = |(bus.req & ~gnt);
`else
  logic unused_lock;
  assign unused_lock = ^bus.lock;
`endif

  always_comb begin
    state_nxt     = state;
    last_nxt      = last;
    gnt_nxt       = gnt;
    owner_nxt     = owner;
    owner_vld_nxt = owner_vld;
    release_bus   = 1'b0;
`ifdef BUS_ARB_PREEMPT_EN
    hold_nxt      = hold_cnt;
    preempt_nxt   = 1'b0;
`endif
    unique case (state)
      ARB_ST_IDLE: begin
        if (pick_any) begin
          state_nxt     = ARB_ST_GRANT;
          gnt_nxt       = NREQ'(arb_onehot(3'(pick_winner)));
          owner_nxt     = pick_winner;
          owner_vld_nxt = 1'b1;
`ifdef BUS_ARB_PREEMPT_EN
          hold_nxt      = '0;
`endif
        end
      end
      ARB_ST_GRANT: begin
        if (!bus.req[owner]) begin
          release_bus = 1'b1;
`ifdef BUS_ARB_PREEMPT_EN
        end else if (hold_cnt == HOLD_LAST && others_req && !bus.lock[owner]) begin
          release_bus = 1'b1;
          preempt_nxt = 1'b1;
        end else if (hold_cnt != HOLD_LAST) begin
          // Saturate at the limit so preemption fires on the first later edge it is allowed.
          hold_nxt = hold_cnt + 8'd1;
`endif
        end
      end
      ARB_ST_TURN: begin
        state_nxt = ARB_ST_IDLE;
      end
      default: begin
        state_nxt     = ARB_ST_IDLE;
        gnt_nxt       = '0;
        owner_vld_nxt = 1'b0;
      end
    endcase

    if (release_bus) begin
      state_nxt     = ARB_ST_TURN;
      gnt_nxt       = '0;
      owner_vld_nxt = 1'b0;
      last_nxt      = owner;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ARB_ST_IDLE;
      last      <= OWNER_W'(NREQ - 1);
      gnt       <= '0;
      owner     <= '0;
      owner_vld <= 1'b0;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      gnt       <= gnt_nxt;
      owner     <= owner_nxt;
      owner_vld <= owner_vld_nxt;
    end
  end

`ifdef BUS_ARB_PREEMPT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      preempt  <= 1'b0;
    end else begin
      hold_cnt <= hold_nxt;
      preempt  <= preempt_nxt;
    end
  end

  assign bus.preempt = preempt;
`else
  assign bus.preempt = 1'b0;
`endif

  assign bus.gnt       = gnt;
  assign bus.owner     = owner;
  assign bus.owner_vld = owner_vld;

endmodule

// File: tb/tb_bus_arbiter_card.sv
// Bench for bus_arbiter_card: directed scenarios plus randomized traffic against a cycle-level reference model.
`timescale 1ns/1ps
module tb_bus_arbiter_card;

  localparam int NREQ     = 4;
  localparam int MAX_HOLD = 4;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic [NREQ-1:0] req   = '0;
  logic [NREQ-1:0] lock  = '0;

  int n_checks = 0;
  int n_pass   = 0;

  bus_arbiter_card_if #(.NREQ(NREQ)) bus ();
  assign bus.req  = req;
  assign bus.lock = lock;

  bus_arbiter_card #(
    .NREQ     (NREQ),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: who holds the bus, how many quiet edges remain after a release,
  // and the most recent releaser for the round-robin search.
  int m_cur   = -1;
  int m_last  = NREQ - 1;
  int m_quiet = 0;
  int m_held  = 0;
  bit m_pre   = 1'b0;
  bit m_ready = 1'b0;

  always @(posedge clk) begin
`ifdef BUS_ARB_PREEMPT_EN
    logic [NREQ-1:0] others;
`endif
    m_pre = 1'b0;
    if (!rst_n) begin
      m_cur   = -1;
      m_last  = NREQ - 1;
      m_quiet = 0;
      m_ready = 1'b1;
    end else if (m_cur >= 0) begin
`ifdef BUS_ARB_PREEMPT_EN
      others = req;
      others[m_cur] = 1'b0;
`endif
      if (!req[m_cur]) begin
        m_last  = m_cur;
        m_cur   = -1;
        m_quiet = 1;
`ifdef BUS_ARB_PREEMPT_EN
      end else if (m_held >= MAX_HOLD - 1 && others != 0 && !lock[m_cur]) begin
        m_last  = m_cur;
        m_cur   = -1;
        m_quiet = 1;
        m_pre   = 1'b1;
`endif
      end else begin
        m_held++;
      end
    end else if (m_quiet > 0) begin
      m_quiet--;
    end else begin
      for (int k = 1; k <= NREQ; k++)
        if (m_cur < 0 && req[(m_last + k) % NREQ]) m_cur = (m_last + k) % NREQ;
      m_held = 0;
    end
  end

  always @(negedge clk) begin
    logic [NREQ-1:0] eg;
    if (m_ready) begin
      eg = (m_cur >= 0) ? (NREQ'(1) << m_cur) : '0;
      chk("model_gnt", int'(bus.gnt), int'(eg));
      chk("model_owner_vld", int'(bus.owner_vld), (m_cur >= 0) ? 1 : 0);
      if (m_cur >= 0) chk("model_owner", int'(bus.owner), m_cur);
      chk("model_preempt", int'(bus.preempt), int'(m_pre));
      chk("gnt_onehot0", ($countones(bus.gnt) <= 1) ? 1 : 0, 1);
    end
  end

  initial begin
    int gap;
    int o;

    // Reset state
    rst_n = 1'b0;
    step(2);
    chk("rst_gnt", int'(bus.gnt), 0);
    chk("rst_owner", int'(bus.owner), 0);
    chk("rst_owner_vld", int'(bus.owner_vld), 0);
    chk("rst_preempt", int'(bus.preempt), 0);
    rst_n = 1'b1;

    // No requests keeps the bus idle; a lone request is granted one edge later
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("idle_gnt", int'(bus.gnt), 0);
      chk("idle_owner_vld", int'(bus.owner_vld), 0);
    end
    req = 4'b0100;
    step(1);
    chk("t1_gnt", int'(bus.gnt), 4'b0100);
    chk("t1_owner", int'(bus.owner), 2);
    req = '0;
    step(4);

    // Fair rotation with everyone requesting, 2-cycle holds
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      gap = 0;
      while (bus.gnt == '0 && gap < 10) begin
        step(1);
        gap++;
      end
      chk("t2_grant_seen", (bus.gnt != '0) ? 1 : 0, 1);
      chk("t2_order", int'(bus.owner), g % NREQ);
      chk("t2_gap", gap, (g == 0) ? 1 : 2);
      o = int'(bus.owner);
      step(1);
      chk("t2_hold", int'(bus.gnt), 1 << (g % NREQ));
      req[o] = 1'b0;
      step(1);
      chk("t2_release", int'(bus.gnt), 0);
      req[o] = 1'b1;
    end
    req = '0;
    step(4);

    // Late requester waits for release + turnaround + arbitration
    req = 4'b0010;
    step(1);
    chk("t3_gnt1", int'(bus.gnt), 4'b0010);
    req = 4'b1010;
    step(1);
    chk("t3_still1", int'(bus.gnt), 4'b0010);
    req = 4'b1000;
    step(1);
    chk("t3_edge_k", int'(bus.gnt), 0);
    step(1);
    chk("t3_edge_k1", int'(bus.gnt), 0);
    step(1);
    chk("t3_edge_k2", int'(bus.gnt), 4'b1000);
    chk("t3_owner3", int'(bus.owner), 3);
    req = '0;
    step(4);

    // Reset while master 1 owns the bus; master 0 wins afterwards
    req = 4'b0010;
    step(1);
    chk("t4_gnt1", int'(bus.gnt), 4'b0010);
    rst_n = 1'b0;
    step(1);
    chk("t4_rst_gnt", int'(bus.gnt), 0);
    chk("t4_rst_vld", int'(bus.owner_vld), 0);
    rst_n = 1'b1;
    req = 4'b0011;
    step(1);
    chk("t4_gnt0", int'(bus.gnt), 4'b0001);
    req = '0;
    step(4);

`ifdef BUS_ARB_PREEMPT_EN
    // Hold limit preempts an unlocked owner on the 4th GRANT edge
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    lock = '0;
    req = 4'b0101;
    step(1);
    chk("p1_gnt0", int'(bus.gnt), 4'b0001);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("p1_no_pre", int'(bus.preempt), 0);
    end
    step(1);
    chk("p1_pre", int'(bus.preempt), 1);
    chk("p1_gnt_off", int'(bus.gnt), 0);
    step(1);
    chk("p1_pre_pulse", int'(bus.preempt), 0);
    step(1);
    chk("p1_gnt2", int'(bus.gnt), 4'b0100);
    req = '0;
    step(4);

    // Locked owner keeps the bus; unlocking preempts on the next edge
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    lock = 4'b0001;
    req = 4'b0101;
    step(1);
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("p2_locked_gnt", int'(bus.gnt), 4'b0001);
      chk("p2_locked_pre", int'(bus.preempt), 0);
    end
    lock = '0;
    step(1);
    chk("p2_unlock_pre", int'(bus.preempt), 1);
    req = '0;
    step(4);
`endif

    // Randomized traffic: fast churn first, then longer holds so the hold limit is reachable
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NREQ; b++)
        if ($urandom_range(0, (c < 1500) ? 3 : 11) == 0) req[b] = ~req[b];
      for (int b = 0; b < NREQ; b++)
        lock[b] = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 299) != 0);
      step(1);
    end
    rst_n = 1'b1;
    req = '0;
    step(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
